// File: rtl/audio_voice_scheduler.sv
// Purpose: shares one triangle voice (period/mute) between NREQ prioritized sound requesters.
// Latency: a request is granted on the edge that samples it; period/mute/active_id update there.
// Backpressure: none; requests are latched in pending bits and served later by priority.
//
// Ports:
//   clk, reset     - system clock; synchronous active-high reset
//   enable         - 0 forces the scheduler idle and muted, dropping all requests
//   req            - one-cycle request pulses, bit i = requester i (higher index wins)
//   req_period     - packed per-requester periods, field i = [i*PERW +: PERW]
//   req_dur        - packed per-requester durations in ticks, field i = [i*DURW +: DURW]
//   period, mute   - registered voice controls
//   busy           - high while playing or in the post-sound gap
//   active_id      - index of the sound playing (holds last value otherwise)
//   done           - one-cycle pulse on natural completion of sound i
module audio_voice_scheduler #(
  parameter int NREQ      = 4,
  parameter int PERW      = 20,
  parameter int DURW      = 8,
  parameter int TICKDIV   = 100000,
  parameter int GAP_TICKS = 2,
  parameter int PREEMPT   = 1,
  localparam int IDW      = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ*PERW-1:0] req_period,
  input  logic [NREQ*DURW-1:0] req_dur,
  output logic [PERW-1:0]      period,
  output logic                 mute,
  output logic                 busy,
  output logic [IDW-1:0]       active_id,
  output logic [NREQ-1:0]      done
);

  localparam int TW = $clog2(TICKDIV);
  localparam int GW = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_PLAY,
    S_GAP
  } state_t;

  state_t          state_q, state_n;
  logic [NREQ-1:0] pending_q, pend_n;
  logic [TW-1:0]   tcnt_q, tcnt_n;
  logic [DURW-1:0] dcnt_q, dcnt_n;
  logic [GW-1:0]   gcnt_q, gcnt_n;
  logic [PERW-1:0] period_n;
  logic            mute_n;
  logic [IDW-1:0]  id_n;
  logic [NREQ-1:0] done_n;

  logic [NREQ-1:0] cand;
  logic            cand_any;
  logic [IDW-1:0]  win;
  logic [PERW-1:0] win_per;
  logic [DURW-1:0] win_dur;
  logic            tick;
  logic            grant;

  assign tick     = (tcnt_q == TW'(TICKDIV - 1));
  assign cand     = pending_q | req;
  assign cand_any = |cand;
  assign busy     = (state_q != S_IDLE);

  // Fixed-priority pick: the ascending scan lets the highest set index win.
  always_comb begin
    win     = '0;
    win_per = '0;
    win_dur = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (cand[i]) begin
        win     = IDW'(i);
        win_per = req_period[i*PERW +: PERW];
        win_dur = req_dur[i*DURW +: DURW];
      end
    end
  end

  always_comb begin
    state_n  = state_q;
    period_n = period;
    mute_n   = mute;
    id_n     = active_id;
    done_n   = '0;
    pend_n   = pending_q | req;
    tcnt_n   = tick ? '0 : tcnt_q + TW'(1);
    dcnt_n   = dcnt_q;
    gcnt_n   = gcnt_q;
    grant    = 1'b0;

    case (state_q)
      S_IDLE: begin
        mute_n = 1'b1;
        if (cand_any) grant = 1'b1;
      end

      S_PLAY: begin
        // Completion takes precedence over any preempting request this cycle;
        // such a request simply stays pending and is served after the gap.
        if (tick && (dcnt_q == DURW'(1))) begin
          done_n[active_id] = 1'b1;
          mute_n            = 1'b1;
          if (GAP_TICKS > 0) begin
            state_n = S_GAP;
            tcnt_n  = '0;
            gcnt_n  = GW'(GAP_TICKS);
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          if (tick) dcnt_n = dcnt_q - DURW'(1);
          // A retrigger of the active id compares equal, so it only pends.
          if ((PREEMPT != 0) && cand_any && (win > active_id)) grant = 1'b1;
        end
      end

      S_GAP: begin
        mute_n = 1'b1;
        if (tick) begin
          gcnt_n = gcnt_q - GW'(1);
          if (gcnt_q == GW'(1)) state_n = S_IDLE;
        end
      end

      default: begin
        state_n = S_IDLE;
        mute_n  = 1'b1;
      end
    endcase

    // A preempted sound is simply overwritten: no done, no gap, not re-pended.
    if (grant) begin
      state_n     = S_PLAY;
      period_n    = win_per;
      mute_n      = 1'b0;
      id_n        = win;
      dcnt_n      = (win_dur == '0) ? DURW'(1) : win_dur;
      tcnt_n      = '0;
      pend_n[win] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      period    <= '0;
      mute      <= 1'b1;
      active_id <= '0;
      done      <= '0;
      pending_q <= '0;
      tcnt_q    <= '0;
      dcnt_q    <= '0;
      gcnt_q    <= '0;
    end else if (!enable) begin
      // Same as reset, but the voice keeps its last period.
      state_q   <= S_IDLE;
      mute      <= 1'b1;
      active_id <= '0;
      done      <= '0;
      pending_q <= '0;
      tcnt_q    <= '0;
      dcnt_q    <= '0;
      gcnt_q    <= '0;
    end else begin
      state_q   <= state_n;
      period    <= period_n;
      mute      <= mute_n;
      active_id <= id_n;
      done      <= done_n;
      pending_q <= pend_n;
      tcnt_q    <= tcnt_n;
      dcnt_q    <= dcnt_n;
      gcnt_q    <= gcnt_n;
    end
  end

endmodule

// File: tb/tb_audio_voice_scheduler.sv
// Purpose: directed, table-driven check of audio_voice_scheduler with TICKDIV=4, GAP_TICKS=2.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: none; every step runs a fixed number of cycles, so the run always ends.
module tb_audio_voice_scheduler;

  localparam int NREQ = 4;
  localparam int PERW = 20;
  localparam int DURW = 8;

  logic                 clk = 1'b0;
  logic                 reset = 1'b1;
  logic                 enable = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [PERW-1:0]      per_v [NREQ];
  logic [DURW-1:0]      dur_v [NREQ];
  logic [NREQ*PERW-1:0] req_period;
  logic [NREQ*DURW-1:0] req_dur;
  logic [PERW-1:0]      period;
  logic                 mute;
  logic                 busy;
  logic [1:0]           active_id;
  logic [NREQ-1:0]      done;

  int n_chk  = 0;
  int n_fail = 0;
  int done_cnt [NREQ];

  assign req_period = {per_v[3], per_v[2], per_v[1], per_v[0]};
  assign req_dur    = {dur_v[3], dur_v[2], dur_v[1], dur_v[0]};

  always #5 clk = ~clk;

  audio_voice_scheduler #(
    .NREQ(NREQ), .PERW(PERW), .DURW(DURW),
    .TICKDIV(4), .GAP_TICKS(2), .PREEMPT(1)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .req(req),
    .req_period(req_period), .req_dur(req_dur),
    .period(period), .mute(mute), .busy(busy),
    .active_id(active_id), .done(done)
  );

  initial for (int i = 0; i < NREQ; i++) done_cnt[i] = 0;

  always @(negedge clk) begin
    for (int i = 0; i < NREQ; i++)
      if (done[i] === 1'b1) done_cnt[i] = done_cnt[i] + 1;
  end

  typedef struct {
    logic       rst;
    logic       en;
    logic [3:0] rq;
    int         n;
    logic       e_mute;
    logic       e_busy;
    logic [1:0] e_id;
    logic [19:0] e_per;
    logic [3:0] e_done;
  } vec_t;

  vec_t tbl [$];

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Drive rst/en for n edges; req is pulsed on the first edge only.
  // done is OR-accumulated over the window; other outputs checked after the last edge.
  task automatic step(input string nm, input logic r, input logic e, input logic [3:0] rq,
                      input int n, input logic em, input logic eb, input logic [1:0] eid,
                      input logic [19:0] eper, input logic [3:0] edone);
    logic [3:0] dacc;
    dacc   = '0;
    reset  = r;
    enable = e;
    req    = rq;
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
      dacc = dacc | done;
      req  = '0;
    end
    chk({nm, ".mute"}, int'(mute), int'(em));
    chk({nm, ".busy"}, int'(busy), int'(eb));
    chk({nm, ".id"}, int'(active_id), int'(eid));
    chk({nm, ".period"}, int'(period), int'(eper));
    chk({nm, ".done"}, int'(dacc), int'(edone));
  endtask

  initial begin
    per_v[0] = 20'd500;  per_v[1] = 20'd1000; per_v[2] = 20'd1500; per_v[3] = 20'd2000;
    dur_v[0] = 8'd2;     dur_v[1] = 8'd3;     dur_v[2] = 8'd1;     dur_v[3] = 8'd2;

    //              rst   en    req      n  mute  busy  id    period    done
    // reset state, then id1 (dur 3): 12 unmuted cycles, done, 8-cycle gap
    tbl.push_back('{1'b1, 1'b1, 4'b0000, 2, 1'b1, 1'b0, 2'd0, 20'd0,    4'b0000});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 3, 1'b1, 1'b0, 2'd0, 20'd0,    4'b0000});
    tbl.push_back('{1'b0, 1'b1, 4'b0010, 1, 1'b0, 1'b1, 2'd1, 20'd1000, 4'b0000});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 11, 1'b0, 1'b1, 2'd1, 20'd1000, 4'b0000});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 1, 1'b1, 1'b1, 2'd1, 20'd1000, 4'b0010});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 7, 1'b1, 1'b1, 2'd1, 20'd1000, 4'b0000});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 1, 1'b1, 1'b0, 2'd1, 20'd1000, 4'b0000});
    // req0+req2 together: id2 first, id0 after the gap with no further stimulus
    tbl.push_back('{1'b0, 1'b1, 4'b0101, 1, 1'b0, 1'b1, 2'd2, 20'd1500, 4'b0000});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 3, 1'b0, 1'b1, 2'd2, 20'd1500, 4'b0000});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 1, 1'b1, 1'b1, 2'd2, 20'd1500, 4'b0100});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 7, 1'b1, 1'b1, 2'd2, 20'd1500, 4'b0000});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 1, 1'b1, 1'b0, 2'd2, 20'd1500, 4'b0000});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 1, 1'b0, 1'b1, 2'd0, 20'd500,  4'b0000});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 7, 1'b0, 1'b1, 2'd0, 20'd500,  4'b0000});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 1, 1'b1, 1'b1, 2'd0, 20'd500,  4'b0001});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 8, 1'b1, 1'b0, 2'd0, 20'd500,  4'b0000});
    // id2 playing, lower-priority req0 must not preempt; id0 follows the gap
    tbl.push_back('{1'b0, 1'b1, 4'b0100, 1, 1'b0, 1'b1, 2'd2, 20'd1500, 4'b0000});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 1, 1'b0, 1'b1, 2'd2, 20'd1500, 4'b0000});
    tbl.push_back('{1'b0, 1'b1, 4'b0001, 1, 1'b0, 1'b1, 2'd2, 20'd1500, 4'b0000});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 2, 1'b1, 1'b1, 2'd2, 20'd1500, 4'b0100});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 8, 1'b1, 1'b0, 2'd2, 20'd1500, 4'b0000});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 1, 1'b0, 1'b1, 2'd0, 20'd500,  4'b0000});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 8, 1'b1, 1'b1, 2'd0, 20'd500,  4'b0001});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 8, 1'b1, 1'b0, 2'd0, 20'd500,  4'b0000});
    // req3 on the completion edge of id0: completion wins, id3 after the gap
    tbl.push_back('{1'b0, 1'b1, 4'b0001, 1, 1'b0, 1'b1, 2'd0, 20'd500,  4'b0000});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 7, 1'b0, 1'b1, 2'd0, 20'd500,  4'b0000});
    tbl.push_back('{1'b0, 1'b1, 4'b1000, 1, 1'b1, 1'b1, 2'd0, 20'd500,  4'b0001});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 8, 1'b1, 1'b0, 2'd0, 20'd500,  4'b0000});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 1, 1'b0, 1'b1, 2'd3, 20'd2000, 4'b0000});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 8, 1'b1, 1'b1, 2'd3, 20'd2000, 4'b1000});
    tbl.push_back('{1'b0, 1'b1, 4'b0000, 8, 1'b1, 1'b0, 2'd3, 20'd2000, 4'b0000});

    for (int i = 0; i < tbl.size(); i++) begin
      step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].en, tbl[i].rq, tbl[i].n,
           tbl[i].e_mute, tbl[i].e_busy, tbl[i].e_id, tbl[i].e_per, tbl[i].e_done);
    end

    // Preemption: id1 (dur 10) aborted by req3 after 4 ticks; id1 never completes or replays.
    dur_v[1] = 8'd10;
    step("pre_grant",  1'b0, 1'b1, 4'b0010, 1,  1'b0, 1'b1, 2'd1, 20'd1000, 4'b0000);
    step("pre_play",   1'b0, 1'b1, 4'b0000, 16, 1'b0, 1'b1, 2'd1, 20'd1000, 4'b0000);
    step("pre_abort",  1'b0, 1'b1, 4'b1000, 1,  1'b0, 1'b1, 2'd3, 20'd2000, 4'b0000);
    step("pre_done3",  1'b0, 1'b1, 4'b0000, 8,  1'b1, 1'b1, 2'd3, 20'd2000, 4'b1000);
    step("pre_gap",    1'b0, 1'b1, 4'b0000, 8,  1'b1, 1'b0, 2'd3, 20'd2000, 4'b0000);
    step("pre_noplay", 1'b0, 1'b1, 4'b0000, 40, 1'b1, 1'b0, 2'd3, 20'd2000, 4'b0000);
    chk("pre_done1_count", done_cnt[1], 1);

    // Duration 0 plays exactly one tick.
    dur_v[1] = 8'd3;
    dur_v[0] = 8'd0;
    step("d0_grant", 1'b0, 1'b1, 4'b0001, 1, 1'b0, 1'b1, 2'd0, 20'd500, 4'b0000);
    step("d0_play",  1'b0, 1'b1, 4'b0000, 3, 1'b0, 1'b1, 2'd0, 20'd500, 4'b0000);
    step("d0_done",  1'b0, 1'b1, 4'b0000, 1, 1'b1, 1'b1, 2'd0, 20'd500, 4'b0001);
    step("d0_gap",   1'b0, 1'b1, 4'b0000, 8, 1'b1, 1'b0, 2'd0, 20'd500, 4'b0000);

    // enable dropped mid-play with id1 pending: muted, idle, period held, pending lost.
    dur_v[2] = 8'd5;
    step("en_grant",   1'b0, 1'b1, 4'b0100, 1,  1'b0, 1'b1, 2'd2, 20'd1500, 4'b0000);
    step("en_pend",    1'b0, 1'b1, 4'b0010, 2,  1'b0, 1'b1, 2'd2, 20'd1500, 4'b0000);
    step("en_off",     1'b0, 1'b0, 4'b0000, 1,  1'b1, 1'b0, 2'd0, 20'd1500, 4'b0000);
    step("en_idle",    1'b0, 1'b1, 4'b0000, 20, 1'b1, 1'b0, 2'd0, 20'd1500, 4'b0000);
    step("en_drop",    1'b0, 1'b0, 4'b1000, 1,  1'b1, 1'b0, 2'd0, 20'd1500, 4'b0000);
    step("en_dropchk", 1'b0, 1'b1, 4'b0000, 5,  1'b1, 1'b0, 2'd0, 20'd1500, 4'b0000);

    // Reset mid-play with pending bits: everything to reset values, no grant until a new req.
    step("rst_grant", 1'b0, 1'b1, 4'b0100, 1,  1'b0, 1'b1, 2'd2, 20'd1500, 4'b0000);
    step("rst_pend",  1'b0, 1'b1, 4'b0011, 2,  1'b0, 1'b1, 2'd2, 20'd1500, 4'b0000);
    step("rst_hit",   1'b1, 1'b1, 4'b0000, 1,  1'b1, 1'b0, 2'd0, 20'd0,    4'b0000);
    step("rst_idle",  1'b0, 1'b1, 4'b0000, 20, 1'b1, 1'b0, 2'd0, 20'd0,    4'b0000);
    step("rst_new",   1'b0, 1'b1, 4'b1000, 1,  1'b0, 1'b1, 2'd3, 20'd2000, 4'b0000);
    step("rst_done",  1'b0, 1'b1, 4'b0000, 8,  1'b1, 1'b1, 2'd3, 20'd2000, 4'b1000);
    step("rst_gap",   1'b0, 1'b1, 4'b0000, 8,  1'b1, 1'b0, 2'd3, 20'd2000, 4'b0000);

    // Total natural completions per requester across the whole run.
    chk("done_total0", done_cnt[0], 4);
    chk("done_total1", done_cnt[1], 1);
    chk("done_total2", done_cnt[2], 2);
    chk("done_total3", done_cnt[3], 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
